// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: loader states and default sizes.
// No logic, no latency.
// No flow control; consumers import these definitions.
package mem_responder_pkg;

  localparam int DEPTH_DEF  = 512;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    LD_IDLE = 2'b00,
    LD_FILL = 2'b01,
    LD_DONE = 2'b10
  } ld_state_t;

endpackage

// File: rtl/mem_responder_ram_array.sv
// Word-addressed RAM: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read is combinational (0 cycles).
// No backpressure; a write is accepted every cycle that we is high.
module mem_responder_ram_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately unreset so contents survive a reset mid-fill.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR bus, with a boot loader that fills RAM from a stream.
// Reads are combinational (0 cycles); writes commit on the next rising edge.
// load_ready is high only while filling; the CPU is held via cpu_hold during fill and done.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  input  logic              read,
  input  logic              ram_we,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_hold,
  output logic              addr_err,
  input  logic              err_clr
);

  ld_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic              in_range;
  logic              busy;
  logic              cpu_ok;
  logic              err_set;

  logic              ram_wen;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Any set bit above the RAM range makes the address invalid, so compare the full word.
  assign in_range = (mar_addr < 32'(DEPTH));
  assign busy     = (state != LD_IDLE);
  assign cpu_ok   = in_range && !busy;
  assign err_set  = (read || ram_we) && !cpu_ok;

  // Read data is the pre-edge RAM word, so a same-cycle write shows the old value.
  assign mem_rdata = (read && cpu_ok) ? ram_rdata : '0;

  // Write port mux: loader owns the port while filling, otherwise the CPU (if legal).
  always_comb begin
    ram_wen   = 1'b0;
    ram_waddr = mar_addr[ADDR_W-1:0];
    ram_wdata = mdr_wdata;
    if (state == LD_FILL) begin
      ram_wen   = load_valid;
      ram_waddr = cnt;
      ram_wdata = load_data;
    end else if (ram_we && cpu_ok) begin
      ram_wen = 1'b1;
    end
  end

  mem_responder_ram_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_wen),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar_addr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Loader state and fill counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Loader next state and outputs; the counter stops at the last word rather than wrapping.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_ready = 1'b0;
    load_done  = 1'b0;
    cpu_hold   = 1'b0;
    case (state)
      LD_IDLE: begin
        if (load_start) begin
          state_nxt = LD_FILL;
          cnt_nxt   = '0;
        end
      end
      LD_FILL: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (load_valid) begin
          if (load_last || (cnt == ADDR_W'(DEPTH - 1))) begin
            state_nxt = LD_DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LD_DONE: begin
        load_done = 1'b1;
        cpu_hold  = 1'b1;
        state_nxt = LD_IDLE;
      end
      default: begin
        state_nxt = LD_IDLE;
      end
    endcase
  end

  // Sticky error flag; a new error in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (err_set) begin
      addr_err <= 1'b1;
    end else if (err_clr) begin
      addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: CPU reads/writes, loader fills, errors, reset abort.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after the edge.
// Expected read data is queued when a read is issued and popped when mem_rdata is sampled.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mar_addr;
  logic [31:0] mdr_wdata;
  logic        read;
  logic        ram_we;
  logic [31:0] mem_rdata;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;
  logic        addr_err;
  logic        err_clr;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mar_addr   (mar_addr),
    .mdr_wdata  (mdr_wdata),
    .read       (read),
    .ram_we     (ram_we),
    .mem_rdata  (mem_rdata),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .cpu_hold   (cpu_hold),
    .addr_err   (addr_err),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample point inside the current cycle, still before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    mar_addr  = a;
    mdr_wdata = d;
    ram_we    = 1'b1;
    step();
    ram_we    = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mar_addr = a;
    read     = 1'b1;
    exp_q.push_back(exp);
    settle();
    check(tag, mem_rdata, exp_q.pop_front());
    step();
    read = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, load_ready}, 32'd0);
    check({tag, "_done"},  {31'd0, load_done},  32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold},   32'd0);
    check({tag, "_err"},   {31'd0, addr_err},   32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    mar_addr   = '0;
    mdr_wdata  = '0;
    read       = 1'b0;
    ram_we     = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    err_clr    = 1'b0;

    // Reset state
    #3;
    check("rst_rdata", mem_rdata, 32'd0);
    check_idle_outputs("rst");
    step();
    step();
    rst = 1'b0;
    step();

    // 1: write then read back next cycle
    cpu_write(32'd5, 32'hDEADBEEF);
    cpu_read("t1_rd5", 32'd5, 32'hDEADBEEF);

    // 2: simultaneous read and write shows old word, new word afterwards
    cpu_write(32'd7, 32'h1);
    mar_addr  = 32'd7;
    mdr_wdata = 32'h2;
    read      = 1'b1;
    ram_we    = 1'b1;
    exp_q.push_back(32'h1);
    settle();
    check("t2_rw_old", mem_rdata, exp_q.pop_front());
    step();
    read   = 1'b0;
    ram_we = 1'b0;
    cpu_read("t2_rd_new", 32'd7, 32'h2);
    check("t2_no_err", {31'd0, addr_err}, 32'd0);

    // 3: three-word fill ending on load_last
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    settle();
    check("t3_ready", {31'd0, load_ready}, 32'd1);
    check("t3_hold",  {31'd0, cpu_hold},   32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA + 32'(i);
      load_last  = (i == 2);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    settle();
    check("t3_done",     {31'd0, load_done},  32'd1);
    check("t3_hold_dn",  {31'd0, cpu_hold},   32'd1);
    check("t3_ready_dn", {31'd0, load_ready}, 32'd0);
    step();
    settle();
    check("t3_done_pulse", {31'd0, load_done}, 32'd0);
    check("t3_hold_fall",  {31'd0, cpu_hold},  32'd0);
    step();
    cpu_read("t3_rd0", 32'd0, 32'hA);
    cpu_read("t3_rd1", 32'd1, 32'hB);
    cpu_read("t3_rd2", 32'd2, 32'hC);

    // CPU access during a fill: read gives 0, write dropped, error raised
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    cpu_read("fill_rd_blocked", 32'd5, 32'd0);
    check("fill_err", {31'd0, addr_err}, 32'd1);
    cpu_write(32'd7, 32'h77);
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 32'h55;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    cpu_read("fill_wr_dropped", 32'd7, 32'h2);
    cpu_read("fill_word0", 32'd0, 32'h55);

    // 4: full-depth fill without load_last; a stray load_start mid-fill is ignored
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 512; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h1000_0000 + 32'(i);
      load_start = (i == 100);
      if (i == 511) begin
        settle();
        check("t4_ready_last", {31'd0, load_ready}, 32'd1);
        #1;
      end
      step();
    end
    load_start = 1'b0;
    load_data  = 32'hBAD0_BAD0;
    settle();
    check("t4_done", {31'd0, load_done}, 32'd1);
    step();
    load_valid = 1'b0;
    settle();
    check("t4_idle_ready", {31'd0, load_ready}, 32'd0);
    step();
    cpu_read("t4_rd0",   32'd0,   32'h1000_0000);
    cpu_read("t4_rd101", 32'd101, 32'h1000_0065);
    cpu_read("t4_rd511", 32'd511, 32'h1000_01FF);

    // 5: out-of-range access and error flag set/clear priority
    cpu_read("t5_oor_rd", 32'h200, 32'd0);
    check("t5_err_set", {31'd0, addr_err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    settle();
    check("t5_err_clr", {31'd0, addr_err}, 32'd0);
    step();
    cpu_write(32'h0000_0205, 32'h5555_5555);
    cpu_read("t5_no_alias", 32'd5, 32'h1000_0005);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    mar_addr = 32'h8000_0005;
    read     = 1'b1;
    err_clr  = 1'b1;
    exp_q.push_back(32'd0);
    settle();
    check("t5_hibit_rd", mem_rdata, exp_q.pop_front());
    step();
    read    = 1'b0;
    err_clr = 1'b0;
    settle();
    check("t5_set_wins", {31'd0, addr_err}, 32'd1);
    step();

    // 6: reset aborts a fill after two words; written words stay
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h6000_0000 + 32'(i);
      step();
    end
    load_valid = 1'b0;
    rst        = 1'b1;
    settle();
    check_idle_outputs("t6_rst");
    check("t6_rst_rdata", mem_rdata, 32'd0);
    step();
    rst = 1'b0;
    step();
    settle();
    check_idle_outputs("t6_post");
    step();
    cpu_read("t6_rd0", 32'd0, 32'h6000_0000);
    cpu_read("t6_rd1", 32'd1, 32'h6000_0001);
    cpu_read("t6_rd2", 32'd2, 32'h1000_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
